// File: rtl/texture_mem_pkg.sv
// texture_mem_pkg: default parameters, derived-width helpers and clear-FSM state for the banked texture memory
package texture_mem_pkg;
    localparam int NUM_ROWS_DEF  = 16;
    localparam int ROW_BITS_DEF  = 128;
    localparam int DEPTH_DEF     = 128;
    localparam int ADDR_W_DEF    = 27;
    localparam int BASE_PAGE_DEF = 1;

    typedef enum logic {IDLE, CLEAR} clr_state_e;

    function automatic int words_per_row(input int row_bits);
        return row_bits / 32;
    endfunction

    function automatic int page_lsb(input int row_bits, input int num_rows, input int depth);
        return 2 + $clog2(row_bits / 32) + $clog2(num_rows) + $clog2(depth);
    endfunction
endpackage

// File: rtl/texture_row_ram.sv
// texture_row_ram: one row bank, DEPTH x ROW_BITS, 32-bit word write, whole-row zero write, registered read
module texture_row_ram import texture_mem_pkg::*; #(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ROW_BITS = ROW_BITS_DEF,
    localparam int EB = $clog2(DEPTH),
    localparam int WB = $clog2(words_per_row(ROW_BITS))
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [EB-1:0]       waddr_i,
    input  logic [WB-1:0]       word_i,
    input  logic [31:0]         wdata_i,
    input  logic                zero_i,
    input  logic [EB-1:0]       zaddr_i,
    input  logic [EB-1:0]       raddr_i,
    output logic [ROW_BITS-1:0] rdata_o
);
    logic [ROW_BITS-1:0] mem_q [DEPTH];
    logic [ROW_BITS-1:0] rdata_q;

    // read samples the array before this edge's write lands, so same-cycle writes stay invisible
    always_ff @(posedge clk) begin
        if (zero_i) mem_q[zaddr_i] <= '0;
        else if (we_i) mem_q[waddr_i][{word_i, 5'b0} +: 32] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/texture_memory_banked.sv
// texture_memory_banked: NUM_ROWS row banks read as one wide entry, 2-cycle read with skid buffer, zero-fill FSM
module texture_memory_banked import texture_mem_pkg::*; #(
    parameter int NUM_ROWS  = NUM_ROWS_DEF,
    parameter int ROW_BITS  = ROW_BITS_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int BASE_PAGE = BASE_PAGE_DEF,
    localparam int WPR      = words_per_row(ROW_BITS),
    localparam int WB       = $clog2(WPR),
    localparam int RB       = $clog2(NUM_ROWS),
    localparam int EB       = $clog2(DEPTH),
    localparam int PAGE_LSB = page_lsb(ROW_BITS, NUM_ROWS, DEPTH),
    localparam int DW       = NUM_ROWS * ROW_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       i_wdata,
    input  logic              i_wea,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic              i_rd_valid,
    input  logic [EB-1:0]     i_texture_idx,
    output logic              o_rd_ready,
    output logic              o_tex_valid,
    input  logic              i_tex_ready,
    output logic [DW-1:0]     o_texture_data,
    input  logic              i_clear,
    output logic              o_busy,
    output logic              o_wr_err
);
    clr_state_e    state_q;
    logic [EB-1:0] cnt_q;
    logic          busy_q, wr_err_q, s1_v_q, skid_v_q, out_v_q;
    logic          skid_v_d, out_v_d, out_free, wr_ok, rd_acc, page_ok, unused_bits;
    logic [DW-1:0] rd_data, skid_data_q, out_data_q;

    assign page_ok     = i_waddr[ADDR_W-1:PAGE_LSB] == (ADDR_W - PAGE_LSB)'(BASE_PAGE);
    assign wr_ok       = i_wea && page_ok && !busy_q;
    assign o_rd_ready  = !busy_q && !(out_v_q && !i_tex_ready);
    assign rd_acc      = i_rd_valid && o_rd_ready;
    assign unused_bits = ^i_waddr[1:0];

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        texture_row_ram #(.DEPTH(DEPTH), .ROW_BITS(ROW_BITS)) u_row (
            .clk     (clk),
            .we_i    (wr_ok && i_waddr[2+WB +: RB] == RB'(r)),
            .waddr_i (i_waddr[2+WB+RB +: EB]),
            .word_i  (i_waddr[2 +: WB]),
            .wdata_i (i_wdata),
            .zero_i  (busy_q),
            .zaddr_i (cnt_q),
            .raddr_i (i_texture_idx),
            .rdata_o (rd_data[r*ROW_BITS +: ROW_BITS])
        );
    end

    // a stalled output diverts the RAM stage into the skid; ready stays low until the output drains
    always_comb begin
        out_free = !out_v_q || i_tex_ready;
        out_v_d  = out_free ? (skid_v_q || s1_v_q) : 1'b1;
        skid_v_d = out_free ? 1'b0 : (skid_v_q || s1_v_q);
    end

    always_ff @(posedge clk) begin
        if (out_free) out_data_q <= skid_v_q ? skid_data_q : rd_data;
        if (!out_free && s1_v_q) skid_data_q <= rd_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            s1_v_q   <= 1'b0;
            skid_v_q <= 1'b0;
            out_v_q  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            s1_v_q   <= rd_acc;
            skid_v_q <= skid_v_d;
            out_v_q  <= out_v_d;
            wr_err_q <= wr_err_q || (i_wea && !wr_ok);
            case (state_q)
                IDLE: if (i_clear) begin
                    state_q <= CLEAR;
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                end
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == EB'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_busy         = busy_q;
    assign o_tex_valid    = out_v_q;
    assign o_texture_data = out_data_q;
    assign o_wr_err       = wr_err_q;
endmodule

// File: tb/tb_texture_memory_banked.sv
// tb_texture_memory_banked: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_texture_memory_banked;
    localparam int DW = 2048;

    logic          clk = 0, rst_n = 0;
    logic [31:0]   i_wdata = '0;
    logic          i_wea = 0, i_rd_valid = 0, i_tex_ready = 1, i_clear = 0;
    logic [26:0]   i_waddr = '0;
    logic [6:0]    i_texture_idx = '0;
    logic          o_rd_ready, o_tex_valid, o_busy, o_wr_err;
    logic [DW-1:0] o_texture_data;

    int            n_tests = 0, n_fail = 0, busy_cnt = 0;
    logic [DW-1:0] model [128];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mon_exp, hold_data;
    logic          hold_chk = 0, tb_busy = 0, acc;
    int            got;

    texture_memory_banked dut (
        .clk(clk), .rst_n(rst_n), .i_wdata(i_wdata), .i_wea(i_wea), .i_waddr(i_waddr),
        .i_rd_valid(i_rd_valid), .i_texture_idx(i_texture_idx), .o_rd_ready(o_rd_ready),
        .o_tex_valid(o_tex_valid), .i_tex_ready(i_tex_ready), .o_texture_data(o_texture_data),
        .i_clear(i_clear), .o_busy(o_busy), .o_wr_err(o_wr_err)
    );

    always #5 clk = ~clk;

    function automatic int first_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int w = 0; w < DW / 32; w++) if (a[w*32 +: 32] !== b[w*32 +: 32]) return w;
        return 0;
    endfunction

    // monitor: pops the scoreboard on every consumed result and checks data holds while stalled
    always @(negedge clk) begin
        if (rst_n && o_tex_valid) begin
            if (hold_chk) begin
                n_tests++;
                if (o_texture_data !== hold_data) begin
                    n_fail++;
                    $display("FAIL hold word %0d got %h exp %h", first_diff(o_texture_data, hold_data),
                             o_texture_data[first_diff(o_texture_data, hold_data)*32 +: 32],
                             hold_data[first_diff(o_texture_data, hold_data)*32 +: 32]);
                end
            end
            if (i_tex_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_unexpected got valid=1 exp no result pending");
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (o_texture_data !== mon_exp) begin
                        n_fail++;
                        $display("FAIL rd_data word %0d got %h exp %h", first_diff(o_texture_data, mon_exp),
                                 o_texture_data[first_diff(o_texture_data, mon_exp)*32 +: 32],
                                 mon_exp[first_diff(o_texture_data, mon_exp)*32 +: 32]);
                    end
                end
            end
            hold_chk  = !i_tex_ready;
            hold_data = o_texture_data;
        end else hold_chk = 0;
        if (o_busy) busy_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", nm, got_v, exp_v);
        end
    endtask

    // one clock of stimulus; a read accepted this cycle sees memory as it was before this cycle's write
    task automatic step(input logic wea, input logic [26:0] addr, input logic [31:0] data,
                        input logic rdv, input logic [6:0] idx, input logic clr, input logic rdy,
                        output logic a);
        i_wea = wea; i_waddr = addr; i_wdata = data; i_rd_valid = rdv;
        i_texture_idx = idx; i_clear = clr; i_tex_ready = rdy;
        #1;
        a = rdv && o_rd_ready;
        if (a) exp_q.push_back(model[idx]);
        if (wea && addr[26:15] == 12'd1 && !tb_busy)
            model[addr[14:8]][addr[7:4]*128 + addr[3:2]*32 +: 32] = data;
        @(posedge clk);
        #1;
        i_wea = 0; i_rd_valid = 0; i_clear = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, 0, 1, acc);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic run_clear(input logic rdv, input logic [6:0] idx);
        busy_cnt = 0;
        step(0, '0, '0, rdv, idx, 1, 1, acc);
        tb_busy = 1;
    endtask

    task automatic finish_clear();
        for (int i = 0; i < 300 && o_busy; i++) idle(1);
        chk("busy_cycles", busy_cnt, 128);
        tb_busy = 0;
        for (int e = 0; e < 128; e++) model[e] = '0;
    endtask

    initial begin
        for (int e = 0; e < 128; e++) model[e] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_tex_valid, 0);
        chk("rst_ready", o_rd_ready, 1);
        chk("rst_wr_err", o_wr_err, 0);

        run_clear(0, '0);
        chk("clr_busy", o_busy, 1);
        finish_clear();

        step(1, 27'h8534, 32'hDEADBEEF, 0, '0, 0, 1, acc);
        step(0, '0, '0, 1, 7'd5, 0, 1, acc);
        chk("lat_accept", acc, 1);
        chk("lat_n1", o_tex_valid, 0);
        idle(1);
        chk("lat_n2", o_tex_valid, 1);
        chk("lat_word", o_texture_data[447:416], 32'hDEADBEEF);
        drain("drain_lat");
        chk("wr_err_clean", o_wr_err, 0);

        step(1, 27'h8700, 32'hA5A5A5A5, 1, 7'd7, 0, 1, acc);
        step(0, '0, '0, 1, 7'd7, 0, 1, acc);
        drain("drain_raw");

        step(1, 27'h8100, 32'h11111111, 0, '0, 0, 1, acc);
        step(1, 27'h8200, 32'h22222222, 0, '0, 0, 1, acc);
        step(1, 27'h8300, 32'h33333333, 0, '0, 0, 1, acc);
        got = 0;
        for (int c = 0; c < 20; c++) begin
            step(0, '0, '0, got < 3, 7'(got + 1), 0, !(c >= 2 && c <= 5), acc);
            if (acc) got++;
            if (c == 2) chk("bp_ready_low", o_rd_ready, 0);
        end
        chk("bp_count", got, 3);
        drain("drain_bp");

        step(1, 27'h10534, 32'hBAD0BAD0, 0, '0, 0, 1, acc);
        chk("page_err", o_wr_err, 1);
        idle(3);
        chk("page_err_sticky", o_wr_err, 1);
        step(0, '0, '0, 1, 7'd5, 0, 1, acc);
        drain("drain_page");

        rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        chk("rst2_wr_err", o_wr_err, 0);

        run_clear(1, 7'd5);
        chk("clr_rd_accept", acc, 1);
        step(1, 27'h8534, 32'h12345678, 0, '0, 0, 1, acc);
        chk("clr_wr_err", o_wr_err, 1);
        chk("clr_rd_blocked", o_rd_ready, 0);
        finish_clear();
        step(0, '0, '0, 1, 7'd5, 0, 1, acc);
        idle(1);
        chk("clr_zero", |o_texture_data, 0);
        drain("drain_clr");

        run_clear(0, '0);
        idle(39);
        rst_n = 0;
        @(posedge clk);
        #1;
        chk("abort_busy", o_busy, 0);
        chk("abort_valid", o_tex_valid, 0);
        rst_n = 1;
        tb_busy = 0;
        chk("abort_ready", o_rd_ready, 1);
        idle(3);
        chk("abort_idle", o_busy, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
